fp_divider_rne: RTL and testbench

- Parametrised successor to the single-precision iterative divider in the Oberon FPU.
- Restoring radix-2 mantissa divider with generic exponent/fraction widths and IEEE round-to-nearest-even using guard and sticky bits.
- Adds full special-operand handling (zero, infinity, NaN) and five exception flags.
- Keeps the CPU's run/stall/ce handshake, so it drops into the RISC5 execute stage beside the multiplier and FP adder.

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_round_rne.sv | 40 ++++
 rtl/fp_divider_rne.sv | 160 ++++++++++++++++
 tb/tb_fp_divider_rne.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and helpers for the iterative floating-point divider.
package fp_pkg;

  typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;

  typedef enum logic [1:0] {ZERO, NORM, INF} opcls_t;

  localparam int FL_NV = 4;
  localparam int FL_DZ = 3;
  localparam int FL_OF = 2;
  localparam int FL_UF = 1;
  localparam int FL_NX = 0;

  // Exponent all-ones is infinity whatever the fraction; zero exponent flushes to zero.
  function automatic opcls_t classify(input logic [31:0] e, input int ew);
    logic [31:0] ones;
    ones = (32'd1 << ew) - 32'd1;
    if (e == 32'd0) return ZERO;
    if (e == ones) return INF;
    return NORM;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised quotient mantissa, then range-check the exponent.
module fp_round_rne #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic                 [MW:0]    mant,
  input  logic                           guard,
  input  logic                           sticky,
  input  logic signed          [EW+1:0]  exp_in,
  output logic                 [EW+MW-1:0] mag,
  output logic                           of,
  output logic                           uf,
  output logic                           nx
);

  localparam logic signed [EW+1:0] EMAX = (EW+2)'((1 << EW) - 1);

  logic                 inc;
  logic                 carry;
  logic [MW-1:0]        frac;
  logic signed [EW+1:0] e;

  // The mantissa always carries its leading one, so a carry-out only happens on all-ones.
  always_comb begin
    inc   = guard & (sticky | mant[0]);
    carry = inc & (&mant);
    frac  = mant[MW-1:0] + MW'(inc);
    e     = exp_in + $signed({{(EW+1){1'b0}}, carry});
    of    = !e[EW+1] && (e >= EMAX);
    uf    = e[EW+1] || (e == '0);
    nx    = guard | sticky | of | uf;
    if (of)
      mag = {{EW{1'b1}}, {MW{1'b0}}};
    else if (uf)
      mag = '0;
    else
      mag = {e[EW-1:0], frac};
  end

endmodule

// File: rtl/fp_divider_rne.sv
// Restoring radix-2 floating-point divider with RNE rounding, IEEE specials and exception flags.
module fp_divider_rne
  import fp_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             run,
  input  logic [EW+MW:0]   x,
  input  logic [EW+MW:0]   y,
  output logic             stall,
  output logic [EW+MW:0]   z,
  output logic [4:0]       flags
);

  localparam int W    = 1 + EW + MW;
  localparam int N    = MW + 3;
  localparam int RW   = MW + 3;
  localparam int CW   = $clog2(N);
  localparam int BIAS = (1 << (EW - 1)) - 1;

  state_t               state, state_nx;
  logic [RW-1:0]        rem;
  logic [N-1:0]         quo;
  logic [CW-1:0]        cnt;
  logic [MW:0]          dvs;
  logic [EW-1:0]        xe_q, ye_q;
  logic                 sgn_q;
  opcls_t               xc_q, yc_q;

  opcls_t               xc_in, yc_in;
  logic                 special_in;
  logic [RW:0]          diff;
  logic                 qbit;
  logic [RW-1:0]        rem_sel;

  logic                 qtop, guard, sticky;
  logic [MW:0]          mant;
  logic signed [EW+1:0] e_pre;
  logic [EW+MW-1:0]     mag;
  logic                 r_of, r_uf, r_nx;
  logic                 nan_c, inf_c, zero_c;
  logic [W-1:0]         z_nx;
  logic [4:0]           fl_nx;

  assign xc_in      = classify(32'(x[W-2:MW]), EW);
  assign yc_in      = classify(32'(y[W-2:MW]), EW);
  assign special_in = (xc_in != NORM) || (yc_in != NORM);

  // Stall tracks run straight through a reset cycle, whatever the state register holds.
  assign stall = run & (rst | (state != DONE));

  assign diff    = {1'b0, rem} - {{(RW-MW){1'b0}}, dvs};
  assign qbit    = ~diff[RW];
  assign rem_sel = qbit ? diff[RW-1:0] : rem;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (run) state_nx = special_in ? ROUND : ITER;
      ITER:    if (cnt == CW'(N - 1)) state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE:    if (!run) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else if (ce)
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (ce && state == IDLE && run) begin
      sgn_q <= x[W-1] ^ y[W-1];
      xe_q  <= x[W-2:MW];
      ye_q  <= y[W-2:MW];
      dvs   <= {1'b1, y[MW-1:0]};
      xc_q  <= xc_in;
      yc_q  <= yc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      z     <= '0;
      flags <= '0;
    end else if (ce) begin
      case (state)
        IDLE: if (run) begin
          rem <= RW'({2'b01, x[MW-1:0]});
          quo <= '0;
          cnt <= '0;
        end
        ITER: begin
          rem <= rem_sel << 1;
          quo <= {quo[N-2:0], qbit};
          cnt <= cnt + CW'(1);
        end
        ROUND: begin
          z     <= z_nx;
          flags <= fl_nx;
        end
        default: ;
      endcase
    end
  end

  // ---- round stage: quotient lies in [2^(N-2), 2^N), normalise on the top bit
  assign qtop   = quo[N-1];
  assign mant   = qtop ? quo[N-1:2] : quo[N-2:1];
  assign guard  = qtop ? quo[1] : quo[0];
  assign sticky = (rem != '0) | (qtop & quo[0]);
  assign e_pre  = $signed({2'b00, xe_q}) - $signed({2'b00, ye_q})
                + $signed((EW+2)'(BIAS - 1)) + $signed({{(EW+1){1'b0}}, qtop});

  fp_round_rne #(.EW(EW), .MW(MW)) u_round (
    .mant   (mant),
    .guard  (guard),
    .sticky (sticky),
    .exp_in (e_pre),
    .mag    (mag),
    .of     (r_of),
    .uf     (r_uf),
    .nx     (r_nx)
  );

  assign nan_c  = (xc_q == ZERO && yc_q == ZERO) || (xc_q == INF && yc_q == INF);
  assign inf_c  = (xc_q == INF) || (yc_q == ZERO && xc_q == NORM);
  assign zero_c = (xc_q == ZERO) || (yc_q == INF);

  always_comb begin
    z_nx         = {sgn_q, mag};
    fl_nx        = '0;
    fl_nx[FL_OF] = r_of;
    fl_nx[FL_UF] = r_uf;
    fl_nx[FL_NX] = r_nx;
    if (nan_c) begin
      z_nx         = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      fl_nx        = '0;
      fl_nx[FL_NV] = 1'b1;
    end else if (inf_c) begin
      z_nx         = {sgn_q, {EW{1'b1}}, {MW{1'b0}}};
      fl_nx        = '0;
      fl_nx[FL_DZ] = (yc_q == ZERO);
    end else if (zero_c) begin
      z_nx  = {sgn_q, {(W-1){1'b0}}};
      fl_nx = '0;
    end
  end

endmodule

// File: tb/tb_fp_divider_rne.sv
// Directed and random checks of fp_divider_rne (single and half precision) against an arithmetic model.
module tb_fp_divider_rne;

  logic        clk, rst, ce, run_f, run_h;
  logic [31:0] x, y;
  logic        stall_f, stall_h;
  logic [31:0] z_f;
  logic [15:0] z_h;
  logic [4:0]  flags_f, flags_h;

  int nassert = 0;
  int nfail   = 0;

  fp_divider_rne #(.EW(8), .MW(23)) dut_f (
    .clk(clk), .rst(rst), .ce(ce), .run(run_f), .x(x), .y(y),
    .stall(stall_f), .z(z_f), .flags(flags_f));

  fp_divider_rne #(.EW(5), .MW(10)) dut_h (
    .clk(clk), .rst(rst), .ce(ce), .run(run_h), .x(x[15:0]), .y(y[15:0]),
    .stall(stall_h), .z(z_h), .flags(flags_h));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer division of the significands, then IEEE RNE with exception rules.
  function automatic void ref_div(input int ew, input int mw, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] zr,
                                  output logic [4:0] fr, output bit sp);
    int     emax, bias, ae, be, e;
    bit     s, az, ai, bz, bi, g, st;
    longint mx, my, num, q, r, m;
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    s  = a[ew+mw] ^ b[ew+mw];
    ae = int'((a >> mw) & 32'(emax));
    be = int'((b >> mw) & 32'(emax));
    mx = longint'(a & ((32'd1 << mw) - 32'd1)) + (longint'(1) << mw);
    my = longint'(b & ((32'd1 << mw) - 32'd1)) + (longint'(1) << mw);
    az = (ae == 0); ai = (ae == emax);
    bz = (be == 0); bi = (be == emax);
    sp = az | ai | bz | bi;
    zr = '0;
    fr = '0;
    if ((az && bz) || (ai && bi)) begin
      zr = (32'(emax) << mw) | (32'd1 << (mw - 1));
      fr = 5'b10000;
    end else if (ai || bz) begin
      zr = (32'(s) << (ew + mw)) | (32'(emax) << mw);
      fr = (bz && !ai) ? 5'b01000 : 5'b00000;
    end else if (az || bi) begin
      zr = 32'(s) << (ew + mw);
    end else begin
      e = ae - be + bias;
      if (mx >= my) num = mx << (mw + 1);
      else begin
        num = mx << (mw + 2);
        e = e - 1;
      end
      q  = num / my;
      r  = num % my;
      g  = q[0];
      st = (r != 0);
      m  = q >>> 1;
      if (g && (st || m[0])) m = m + 1;
      if (m == (longint'(1) << (mw + 1))) begin
        m = m >>> 1;
        e = e + 1;
      end
      if (e >= emax) begin
        zr = (32'(s) << (ew + mw)) | (32'(emax) << mw);
        fr = 5'b00101;
      end else if (e <= 0) begin
        zr = 32'(s) << (ew + mw);
        fr = 5'b00011;
      end else begin
        zr = (32'(s) << (ew + mw)) | (32'(e) << mw) | 32'(m & ((longint'(1) << mw) - 1));
        fr = {4'b0000, g | st};
      end
    end
  endfunction

  // Count enabled stall cycles until stall drops; operands are scrambled once latched.
  task automatic wait_done(input bit half, input bit tog, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int k = 0; k < 400; k++) begin
      #1;
      if (!(half ? stall_h : stall_f)) begin
        ok = 1'b1;
        break;
      end
      if (ce) cyc++;
      @(negedge clk);
      x = $urandom;
      y = $urandom;
      if (tog) ce = ~ce;
    end
    ce = 1'b1;
  endtask

  task automatic do_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                       input bit tog, input string tag,
                       output logic [31:0] zo, output logic [4:0] fo);
    logic [31:0] ez;
    logic [4:0]  ef;
    bit          sp, ok;
    int          cyc, mw;
    mw = half ? 10 : 23;
    ref_div(half ? 5 : 8, mw, a, b, ez, ef, sp);
    @(negedge clk);
    x = a;
    y = b;
    if (half) run_h = 1'b1; else run_f = 1'b1;
    wait_done(half, tog, cyc, ok);
    chk({tag, "_done"}, 32'(ok), 32'd1);
    zo = half ? 32'(z_h) : z_f;
    fo = half ? flags_h : flags_f;
    chk({tag, "_z"}, zo, ez);
    chk({tag, "_flags"}, 32'(fo), 32'(ef));
    chk({tag, "_stall"}, 32'(cyc), sp ? 32'd2 : 32'(mw + 5));
    repeat (2) @(negedge clk);
    #1;
    chk({tag, "_hold"}, half ? 32'(z_h) : z_f, ez);
    run_f = 1'b0;
    run_h = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] da [8] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000,
                          32'h00000000, 32'hC0000000, 32'h7F000000, 32'h00800000};
  logic [31:0] db [8] = '{32'h3F800000, 32'h40400000, 32'h40400000, 32'h00000000,
                          32'h00000000, 32'h7F800000, 32'h00800000, 32'h7F000000};
  logic [31:0] dz [8] = '{32'h3F800000, 32'h3EAAAAAB, 32'h3F2AAAAB, 32'h7F800000,
                          32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h00000000};
  logic [4:0]  df [8] = '{5'h00, 5'h01, 5'h01, 5'h08, 5'h10, 5'h00, 5'h05, 5'h03};

  initial begin
    logic [31:0] zo, a, b;
    logic [4:0]  fo;
    int          cyc;
    bit          ok;

    rst = 1'b1; ce = 1'b1; run_f = 1'b0; run_h = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_z_f", z_f, 32'd0);
    chk("rst_flags_f", 32'(flags_f), 32'd0);
    chk("rst_z_h", 32'(z_h), 32'd0);
    chk("rst_stall_idle", 32'(stall_f), 32'd0);
    run_f = 1'b1;
    #1;
    chk("rst_stall_run", 32'(stall_f), 32'd1);
    run_f = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, da[i], db[i], 1'b0, $sformatf("dir%0d", i), zo, fo);
      chk($sformatf("dir%0d_zconst", i), zo, dz[i]);
      chk($sformatf("dir%0d_fconst", i), 32'(fo), 32'(df[i]));
    end

    do_op(1'b0, 32'h3F800000, 32'h40400000, 1'b1, "ce_toggle", zo, fo);
    chk("ce_toggle_zconst", zo, 32'h3EAAAAAB);

    // Abort after ten iterations with run held; a fresh operation follows the reset.
    @(negedge clk);
    x = 32'h3F800000;
    y = 32'h40400000;
    run_f = 1'b1;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_stall", 32'(stall_f), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_z", z_f, 32'd0);
    chk("midrst_flags", 32'(flags_f), 32'd0);
    chk("midrst_idle_stall", 32'(stall_f), 32'd1);
    wait_done(1'b0, 1'b0, cyc, ok);
    chk("midrst_done", 32'(ok), 32'd1);
    chk("midrst_cycles", 32'(cyc), 32'd28);
    chk("midrst_result", z_f, 32'h3EAAAAAB);
    run_f = 1'b0;
    repeat (2) @(negedge clk);

    do_op(1'b1, 32'h3C00, 32'h4200, 1'b0, "half_third", zo, fo);
    chk("half_third_zconst", zo, 32'h3555);
    chk("half_third_fconst", 32'(fo), 32'h01);
    do_op(1'b1, 32'h7BFF, 32'h0400, 1'b0, "half_ovf", zo, fo);
    chk("half_ovf_zconst", zo, 32'h7C00);
    chk("half_ovf_fconst", 32'(fo), 32'h05);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: a[30:23] = 8'h00;
        1: b[30:23] = 8'h00;
        2: a[30:23] = 8'hFF;
        3: b[30:23] = 8'hFF;
        default: ;
      endcase
      do_op(1'b0, a, b, i[0], $sformatf("rnd_f%0d", i), zo, fo);
    end

    for (int i = 0; i < 25; i++) begin
      a = $urandom & 32'hFFFF;
      b = $urandom & 32'hFFFF;
      do_op(1'b1, a, b, i[0], $sformatf("rnd_h%0d", i), zo, fo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
